// File: rtl/ips_wb_bridge_if.sv
// Bus bundle for ips_wb_bridge: upstream Wishbone slave port plus the
// NSLV-wide downstream fan-out. "slave" is the bridge's view, "master" the SoC/peripheral side.
interface ips_wb_bridge_if #(
  parameter int unsigned NSLV = 4
);
  logic                 wbs_cyc_i;
  logic                 wbs_stb_i;
  logic                 wbs_we_i;
  logic [3:0]           wbs_sel_i;
  logic [31:0]          wbs_adr_i;
  logic [31:0]          wbs_dat_i;
  logic                 wbs_ack_o;
  logic [31:0]          wbs_dat_o;
  logic [NSLV-1:0]      m_cyc_o;
  logic                 m_stb_o;
  logic                 m_we_o;
  logic [3:0]           m_sel_o;
  logic [31:0]          m_adr_o;
  logic [31:0]          m_dat_o;
  logic [NSLV-1:0]      m_ack_i;
  logic [32*NSLV-1:0]   m_dat_i;
  logic                 err_irq_o;

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  m_ack_i, m_dat_i,
    output wbs_ack_o, wbs_dat_o, m_cyc_o, m_stb_o, m_we_o, m_sel_o,
    output m_adr_o, m_dat_o, err_irq_o
  );

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output m_ack_i, m_dat_i,
    input  wbs_ack_o, wbs_dat_o, m_cyc_o, m_stb_o, m_we_o, m_sel_o,
    input  m_adr_o, m_dat_o, err_irq_o
  );
endinterface

// File: rtl/ips_wb_bridge.sv
// Wishbone decoder/bridge from the user-area slave port to NSLV peripheral windows.
// Optional error statistics (err_cnt_o, last_err_adr_o) under `define WB_BRIDGE_ERR_CNT_EN.
module ips_wb_bridge #(
  parameter int unsigned NSLV     = 4,
  parameter logic [7:0]  BASE_HI  = 8'h30,
  parameter int unsigned SLV_LSB  = 16,
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] ERR_WORD = 32'hDEAD_BEEF
) (
  input logic            wb_clk_i,
  input logic            wb_rst_n,
  ips_wb_bridge_if.slave bus
`ifdef WB_BRIDGE_ERR_CNT_EN
  ,
  output logic [15:0]    err_cnt_o,
  output logic [31:0]    last_err_adr_o
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]      state;
  logic [15:0]     timer;
  logic            req;
  logic            hit;
  logic            sel_ack;
  logic            timed_out;
  logic [2:0]      req_idx;
  logic [NSLV-1:0] req_onehot;
  logic [31:0]     sel_dat;

  // m_cyc_o is one-hot on the selected slave while waiting, so it doubles as the ack/data mux select.
  always_comb begin
    req        = bus.wbs_cyc_i & bus.wbs_stb_i;
    req_idx    = bus.wbs_adr_i[SLV_LSB+2:SLV_LSB];
    hit        = (bus.wbs_adr_i[31:24] == BASE_HI) && (32'(req_idx) < NSLV);
    timed_out  = (timer == 16'(TIMEOUT - 1));
    sel_ack    = |(bus.m_ack_i & bus.m_cyc_o);
    req_onehot = '0;
    sel_dat    = '0;
    for (int unsigned k = 0; k < NSLV; k++) begin
      if (req_idx == 3'(k)) req_onehot[k] = 1'b1;
      if (bus.m_cyc_o[k])   sel_dat = bus.m_dat_i[32*k +: 32];
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state         <= S_IDLE;
      timer         <= '0;
      bus.wbs_ack_o <= 1'b0;
      bus.wbs_dat_o <= '0;
      bus.err_irq_o <= 1'b0;
      bus.m_cyc_o   <= '0;
      bus.m_stb_o   <= 1'b0;
      bus.m_we_o    <= 1'b0;
      bus.m_sel_o   <= '0;
      bus.m_adr_o   <= '0;
      bus.m_dat_o   <= '0;
    end else begin
      bus.wbs_ack_o <= 1'b0;
      bus.wbs_dat_o <= '0;
      bus.err_irq_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req) begin
            if (hit) begin
              bus.m_cyc_o <= req_onehot;
              bus.m_stb_o <= 1'b1;
              bus.m_we_o  <= bus.wbs_we_i;
              bus.m_sel_o <= bus.wbs_sel_i;
              bus.m_adr_o <= bus.wbs_adr_i;
              bus.m_dat_o <= bus.wbs_dat_i;
              timer       <= '0;
              state       <= S_WAIT;
            end else begin
              bus.wbs_ack_o <= 1'b1;
              bus.wbs_dat_o <= ERR_WORD;
              bus.err_irq_o <= 1'b1;
              state         <= S_RESP;
            end
          end
        end
        S_WAIT: begin
          // Abort is tested first so it wins over a coincident slave ack.
          if (!bus.wbs_cyc_i) begin
            bus.m_cyc_o <= '0;
            bus.m_stb_o <= 1'b0;
            state       <= S_IDLE;
          end else if (sel_ack) begin
            bus.m_cyc_o   <= '0;
            bus.m_stb_o   <= 1'b0;
            bus.wbs_ack_o <= 1'b1;
            bus.wbs_dat_o <= bus.m_we_o ? '0 : sel_dat;
            state         <= S_RESP;
          end else if (timed_out) begin
            bus.m_cyc_o   <= '0;
            bus.m_stb_o   <= 1'b0;
            bus.wbs_ack_o <= 1'b1;
            bus.wbs_dat_o <= ERR_WORD;
            bus.err_irq_o <= 1'b1;
            state         <= S_RESP;
          end else begin
            timer <= timer + 16'd1;
          end
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef WB_BRIDGE_ERR_CNT_EN
  logic        err_set;
  logic [31:0] err_adr;

  assign err_set = ((state == S_IDLE) && req && !hit) ||
                   ((state == S_WAIT) && bus.wbs_cyc_i && !sel_ack && timed_out);
  assign err_adr = (state == S_IDLE) ? bus.wbs_adr_i : bus.m_adr_o;

  // Updated on the edge entering RESP so the new values are visible alongside the error ack.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      err_cnt_o      <= '0;
      last_err_adr_o <= '0;
    end else if (err_set) begin
      if (err_cnt_o != '1) err_cnt_o <= err_cnt_o + 16'd1;
      last_err_adr_o <= err_adr;
    end
  end
`endif

endmodule

// File: tb/tb_ips_wb_bridge.sv
// Scoreboard bench for ips_wb_bridge: directed cases then randomized traffic against
// a transaction-level model of decode, latency, timeout and error responses.
module tb_ips_wb_bridge;
  localparam int          NSLV     = 4;
  localparam int          TIMEOUT  = 255;
  localparam logic [31:0] ERR_WORD = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ips_wb_bridge_if #(.NSLV(NSLV)) bus ();
`ifdef WB_BRIDGE_ERR_CNT_EN
  logic [15:0] err_cnt;
  logic [31:0] last_err_adr;
`endif

  ips_wb_bridge #(.NSLV(NSLV), .BASE_HI(8'h30), .SLV_LSB(16), .TIMEOUT(TIMEOUT), .ERR_WORD(ERR_WORD)) dut (
    .wb_clk_i (clk),
    .wb_rst_n (rst_n),
    .bus      (bus)
`ifdef WB_BRIDGE_ERR_CNT_EN
    ,
    .err_cnt_o      (err_cnt),
    .last_err_adr_o (last_err_adr)
`endif
  );

  longint cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [31:0] dat;
    logic        err;
    longint      at;
    logic [31:0] adr;
  } up_t;
  typedef struct {
    logic [NSLV-1:0] cyc;
    logic [31:0]     adr;
    logic [31:0]     dat;
    logic            we;
    logic [3:0]      sel;
    longint          at;
  } ds_t;

  up_t up_q[$];
  ds_t ds_q[$];

  int          slv_idx = 0;
  int          slv_delay = -1;
  logic [31:0] slv_data = '0;
  bit          spur_en = 1'b0;
  int          wcnt = 0;
  logic        rsp_stb_prev = 1'b0;
  logic        mon_stb_prev = 1'b0;
  int unsigned model_cnt = 0;
  logic [31:0] model_last = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Downstream slaves: target acks after slv_delay cycles of strobe; others may ack spuriously.
  always @(negedge clk) begin
    if (!rst_n || !bus.m_stb_o) begin
      wcnt = 0;
      rsp_stb_prev = 1'b0;
      bus.m_ack_i = '0;
    end else begin
      wcnt = rsp_stb_prev ? wcnt + 1 : 0;
      rsp_stb_prev = 1'b1;
      for (int k = 0; k < NSLV; k++)
        bus.m_ack_i[k] = (k == slv_idx) ? (wcnt == slv_delay) : (spur_en && ($urandom_range(0, 3) == 0));
    end
    for (int k = 0; k < NSLV; k++)
      bus.m_dat_i[32*k +: 32] = (k == slv_idx) ? slv_data : $urandom;
  end

  // Monitor: pops expectations when the DUT strobes downstream or acks upstream.
  always @(negedge clk) begin
    up_t u;
    ds_t d;
    if (!rst_n) begin
      mon_stb_prev = 1'b0;
    end else begin
      if (!bus.wbs_ack_o) begin
        check("idle_dat", 64'(bus.wbs_dat_o), 64'(0));
        check("idle_irq", 64'(bus.err_irq_o), 64'(0));
      end else if (up_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_ack: got ack dat %0h, required no ack (t=%0t)", bus.wbs_dat_o, $time);
      end else begin
        u = up_q.pop_front();
        check("ack_dat", 64'(bus.wbs_dat_o), 64'(u.dat));
        check("ack_irq", 64'(bus.err_irq_o), 64'(u.err));
        check("ack_cycle", 64'(cyc_cnt), 64'(u.at));
        check("ack_ds_dropped", 64'({bus.m_cyc_o, bus.m_stb_o}), 64'(0));
`ifdef WB_BRIDGE_ERR_CNT_EN
        if (u.err) begin
          if (model_cnt < 65535) model_cnt++;
          model_last = u.adr;
        end
        check("err_cnt", 64'(err_cnt), 64'(model_cnt));
        check("last_err_adr", 64'(last_err_adr), 64'(model_last));
`endif
      end
      if (bus.m_stb_o && !mon_stb_prev) begin
        if (ds_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_strobe: got m_cyc %0h, required no strobe (t=%0t)", bus.m_cyc_o, $time);
        end else begin
          d = ds_q.pop_front();
          check("ds_cyc", 64'(bus.m_cyc_o), 64'(d.cyc));
          check("ds_adr", 64'(bus.m_adr_o), 64'(d.adr));
          check("ds_dat", 64'(bus.m_dat_o), 64'(d.dat));
          check("ds_we", 64'(bus.m_we_o), 64'(d.we));
          check("ds_sel", 64'(bus.m_sel_o), 64'(d.sel));
          check("ds_cycle", 64'(cyc_cnt), 64'(d.at));
        end
      end
      mon_stb_prev = bus.m_stb_o;
    end
  end

  // Called at a negedge; dly<0 means the target never acks.
  task automatic start_req(input logic [31:0] adr, input logic we, input logic [3:0] sel,
                           input logic [31:0] wdat, input int dly, input logic [31:0] rdat,
                           input bit expect_up);
    up_t    u;
    ds_t    d;
    int     idx;
    bit     hit;
    longint c0;
    c0  = cyc_cnt;
    idx = int'(adr[18:16]);
    hit = (adr[31:24] == 8'h30) && (idx < NSLV);
    u.adr = adr;
    if (!hit) begin
      u.dat = ERR_WORD; u.err = 1'b1; u.at = c0 + 1;
    end else begin
      d.cyc = '0;
      d.cyc[idx] = 1'b1;
      d.adr = adr; d.dat = wdat; d.we = we; d.sel = sel; d.at = c0 + 1;
      ds_q.push_back(d);
      if (dly >= 0 && dly < TIMEOUT) begin
        u.dat = we ? 32'h0 : rdat; u.err = 1'b0; u.at = c0 + 2 + dly;
      end else begin
        u.dat = ERR_WORD; u.err = 1'b1; u.at = c0 + 1 + TIMEOUT;
      end
    end
    if (expect_up) up_q.push_back(u);
    slv_idx   = hit ? idx : -1;
    slv_delay = dly;
    slv_data  = rdat;
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_we_i  = we;
    bus.wbs_sel_i = sel;
    bus.wbs_adr_i = adr;
    bus.wbs_dat_i = wdat;
  endtask

  task automatic drop_req();
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
  endtask

  task automatic finish_req();
    int n;
    for (n = 0; n < TIMEOUT + 20; n++) begin
      @(negedge clk);
      if (bus.wbs_ack_o) break;
    end
    if (n == TIMEOUT + 20) begin
      vectors++;
      miscompares++;
      $display("FAIL ack_wait: got no ack in %0d cycles, required an ack", TIMEOUT + 20);
    end
    drop_req();
  endtask

  task automatic txn(input logic [31:0] adr, input logic we, input logic [3:0] sel,
                     input logic [31:0] wdat, input int dly, input logic [31:0] rdat);
    @(negedge clk);
    start_req(adr, we, sel, wdat, dly, rdat, 1'b1);
    finish_req();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] adr;
    int          dly;
    int          r;
`ifdef WB_BRIDGE_ERR_CNT_EN
    logic [15:0] cnt_before;
`endif
    bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
    bus.wbs_sel_i = '0;   bus.wbs_adr_i = '0;   bus.wbs_dat_i = '0;
    bus.m_ack_i = '0;     bus.m_dat_i = '0;
    repeat (3) @(negedge clk);
    check("rst_ack", 64'(bus.wbs_ack_o), 64'(0));
    check("rst_dat", 64'(bus.wbs_dat_o), 64'(0));
    check("rst_irq", 64'(bus.err_irq_o), 64'(0));
    check("rst_cyc_stb_we", 64'({bus.m_cyc_o, bus.m_stb_o, bus.m_we_o}), 64'(0));
    check("rst_sel", 64'(bus.m_sel_o), 64'(0));
    check("rst_adr", 64'(bus.m_adr_o), 64'(0));
    check("rst_mdat", 64'(bus.m_dat_o), 64'(0));
    rst_n = 1'b1;

    txn(32'h3002_0010, 1'b0, 4'hF, 32'h0, 3, 32'h1234_5678);
    txn(32'h3000_0004, 1'b1, 4'b0011, 32'hA5A5_A5A5, 1, 32'h5555_0000);
    txn(32'h3105_0000, 1'b0, 4'hF, 32'h0, 0, 32'h0);
    txn(32'h3004_0000, 1'b0, 4'hF, 32'h0, 0, 32'h0);
    spur_en = 1'b1;
    txn(32'h3001_0000, 1'b0, 4'hF, 32'h0, -1, 32'h7777_7777);
    txn(32'h3003_0020, 1'b0, 4'hF, 32'h0, TIMEOUT - 1, 32'hCAFE_F00D);
    spur_en = 1'b0;
    txn(32'h3001_0040, 1'b0, 4'hF, 32'h0, 0, 32'h0BAD_CAFE);

    // Abort coinciding with the selected slave's ack: no upstream ack expected.
`ifdef WB_BRIDGE_ERR_CNT_EN
    cnt_before = err_cnt;
`endif
    @(negedge clk);
    start_req(32'h3001_0008, 1'b0, 4'hF, 32'h0, 6, 32'h1111_2222, 1'b0);
    repeat (7) @(negedge clk);
    drop_req();
    @(negedge clk);
    check("abort_cyc", 64'(bus.m_cyc_o), 64'(0));
    check("abort_stb", 64'(bus.m_stb_o), 64'(0));
    repeat (3) @(negedge clk);
`ifdef WB_BRIDGE_ERR_CNT_EN
    check("abort_err_cnt", 64'(err_cnt), 64'(cnt_before));
`endif
    txn(32'h3002_0000, 1'b0, 4'hF, 32'h0, 2, 32'h3333_4444);

    // Reset during a wait: everything drops at once.
    @(negedge clk);
    start_req(32'h3002_0000, 1'b1, 4'hF, 32'h9999_0000, -1, 32'h0, 1'b0);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rstmid_cyc_stb", 64'({bus.m_cyc_o, bus.m_stb_o}), 64'(0));
    check("rstmid_ack_irq", 64'({bus.wbs_ack_o, bus.err_irq_o}), 64'(0));
    model_cnt = 0;
    model_last = '0;
    @(negedge clk);
    drop_req();
    @(negedge clk);
    rst_n = 1'b1;
`ifdef WB_BRIDGE_ERR_CNT_EN
    check("rstmid_err_cnt", 64'(err_cnt), 64'(0));
`endif

    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 9);
      if (r < 7)      adr = {8'h30, 5'($urandom), 3'($urandom_range(0, NSLV - 1)), 16'($urandom)};
      else if (r < 9) adr = {8'h30, 5'($urandom), 3'($urandom_range(NSLV, 7)), 16'($urandom)};
      else            adr = $urandom;
      r = $urandom_range(0, 19);
      if (r == 0)      dly = -1;
      else if (r == 1) dly = TIMEOUT - 1;
      else if (r == 2) dly = TIMEOUT;
      else             dly = $urandom_range(0, 6);
      spur_en = 1'($urandom);
      txn(adr, 1'($urandom), 4'($urandom), $urandom, dly, $urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    check("up_q_drained", 64'(up_q.size()), 64'(0));
    check("ds_q_drained", 64'(ds_q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/ips_wb_bridge.md
Name: ips_wb_bridge

Overview:
- Wishbone address decoder/bridge between the user-area Wishbone slave port (management SoC side) and the peripheral IPs inside the caravel_ips user block.
- Decodes each upstream cycle to one of NSLV downstream slave windows and registers the downstream request.
- Waits for the selected slave's ack, then returns data upstream.
- Unmapped accesses and stalled slaves are terminated with an error word and a one-cycle error IRQ pulse.

Parameters:
- NSLV, 4, number of downstream slaves (1..8).
- BASE_HI, 8'h30, required value of wbs_adr_i[31:24] for a hit.
- SLV_LSB, 16, LSB of the slave index field; index = wbs_adr_i[SLV_LSB+2:SLV_LSB].
- TIMEOUT, 255, cycles in WAIT before forced termination (1..65535).
- ERR_WORD, 32'hDEAD_BEEF, data returned on error termination.

Ports:
- wb_clk_i  in  1  bus clock, single clock domain.
- wb_rst_n  in  1  asynchronous, active-low reset.
- wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  upstream Wishbone controls.
- wbs_sel_i  in  4  byte selects.
- wbs_adr_i, wbs_dat_i  in  32 each  upstream address and write data.
- wbs_ack_o  out  1  upstream ack.
- wbs_dat_o  out  32  upstream read data.
- m_cyc_o  out  NSLV  one-hot downstream cyc.
- m_stb_o, m_we_o  out  1 each  shared downstream strobe and write enable.
- m_sel_o  out  4  downstream byte selects.
- m_adr_o, m_dat_o  out  32 each  downstream address and write data (registered copies).
- m_ack_i  in  NSLV  per-slave ack.
- m_dat_i  in  32*NSLV  per-slave read data; slave k occupies [32k+31:32k].
- err_irq_o  out  1  one-cycle pulse on any error termination.

Behaviour:
- Reset (wb_rst_n=0, asynchronous): state=IDLE; all outputs 0; timer 0.
- FSM states: IDLE, WAIT, RESP.
- IDLE, on wbs_cyc_i & wbs_stb_i:
  - Hit (adr[31:24]==BASE_HI and index<NSLV): latch adr/dat/sel/we/index; next edge drive m_cyc_o[index]=1, m_stb_o=1; go WAIT.
  - Miss: go RESP with error (ERR_WORD, err_irq_o=1); no downstream activity.
- WAIT:
  - Timer increments each cycle.
  - m_ack_i[index]=1: capture m_dat_i slice; drop m_cyc_o/m_stb_o on the next edge; go RESP (good).
  - Acks from non-selected slaves are ignored.
  - Timer reaches TIMEOUT with no ack: drop downstream; go RESP with error.
  - Upstream abort (wbs_cyc_i=0): drop downstream next edge; go IDLE; no upstream ack; no IRQ.
  - Ack and abort in the same cycle: the abort wins.
- RESP: wbs_ack_o=1 for exactly one cycle.
  - wbs_dat_o = captured data on reads, 0 on writes, ERR_WORD on errors.
  - err_irq_o is high in this same cycle for errors only.
  - Next state IDLE. Request inputs are not sampled while in RESP.
- wbs_dat_o=0 whenever wbs_ack_o=0.
- Latency: request seen in cycle 0 → m_stb_o high in cycle 1 → slave ack in cycle k → wbs_ack_o in cycle k+1. A miss acks in cycle 1.
- Minimum spacing: one IDLE cycle between transactions, so back-to-back throughput is at best one transfer per 3 cycles.
- Asserting reset mid-transaction drops all downstream and upstream signals immediately; no ack is issued.

Optional Feature:
- Macro WB_BRIDGE_ERR_CNT_EN.
- When defined:
  - Adds output err_cnt_o[15:0]: saturating count of error terminations, cleared only by reset.
  - Adds output last_err_adr_o[31:0]: address of the most recent error.
  - Both update on the RESP cycle of an error.
- When undefined: these ports and registers are absent; behaviour is otherwise identical.

Test Plan:
- Read slave 2 at 0x3002_0010, slave acks 3 cycles after strobe with 0x1234_5678 → m_cyc_o=4'b0100; wbs_ack_o one cycle later with 0x1234_5678; err_irq_o=0.
- Write 0xA5A5_A5A5, sel=4'b0011, to slave 0 at 0x3000_0004 → m_we_o=1, m_dat_o=0xA5A5_A5A5, m_sel_o=4'b0011; one-cycle ack with wbs_dat_o=0.
- Access 0x3105_0000 (base miss), then 0x3004_0000 (index 4 ≥ NSLV) → each acked in cycle 1 with 0xDEAD_BEEF; err_irq_o pulses; m_cyc_o stays 0.
- Slave 1 never acks; slave 3 acks spuriously during the wait → after 255 WAIT cycles, ack with 0xDEAD_BEEF, err_irq_o pulse, m_cyc_o cleared; the spurious ack is ignored.
- Drop wbs_cyc_i during WAIT, then assert reset during a second WAIT → no upstream ack, m_cyc_o=0 next cycle, FSM idle; with WB_BRIDGE_ERR_CNT_EN defined, err_cnt_o unchanged by the abort and 0 after reset.
